// File: rtl/mmio_uart_tx.sv
// MMIO-fed UART transmitter: rising edges of disp_wea queue disp_dat[7:0] into a byte FIFO,
// and an 8N1 serializer drains the FIFO onto tx.
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          Rst,
  input  logic                          disp_wea,
  input  logic [31:0]                   disp_dat,
  input  logic                          ovf_clr,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic          wea_q;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic unused_dat;
  assign unused_dat = ^disp_dat[31:8];

  assign push       = disp_wea & ~wea_q;
  assign pop        = (state == IDLE) && (fifo_count != '0);
  // A full FIFO still accepts a push when the serializer frees a slot on the same edge.
  assign push_ok    = push && ((fifo_count != FULL_CNT) || pop);
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_CNT);
  assign tx_busy    = (state != IDLE);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      wea_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf        <= 1'b0;
    end else begin
      wea_q <= disp_wea;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && !push_ok) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= disp_dat[7:0];
  end

  // tx follows the state held over the previous cycle, which yields the two-edge start latency
  // and exactly one idle-high cycle between back-to-back frames.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          clk_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          tx <= shift[0];
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            shift   <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4;
// tx is logged every cycle and decoded into frames for comparison.
module tb_mmio_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        disp_wea = 1'b0;
  logic [31:0] disp_dat = '0;
  logic        ovf_clr = 1'b0;
  logic        tx, tx_busy, fifo_empty, fifo_full, ovf;
  logic [2:0]  fifo_count;

  int compared = 0;
  int mismatched = 0;

  logic       rec_on = 1'b0;
  logic       tx_log[$];
  int         busy_total;
  int         count_peak;
  logic [7:0] got_bytes[$];
  int         gaps[$];
  int         first_start;
  int         bad_frames;

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .Rst(Rst), .disp_wea(disp_wea), .disp_dat(disp_dat), .ovf_clr(ovf_clr),
    .tx(tx), .tx_busy(tx_busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // One log entry per cycle, sampled midway between rising edges.
  always @(negedge clk) begin
    if (rec_on) begin
      tx_log.push_back(tx);
      if (tx_busy) busy_total++;
      if (int'(fifo_count) > count_peak) count_peak = int'(fifo_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    Rst = 1'b1;
    disp_wea = 1'b0;
    ovf_clr = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
    tx_log.delete();
    busy_total = 0;
    count_peak = 0;
    rec_on = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input int hold);
    disp_dat = {24'hABCDEF, b};
    disp_wea = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    disp_wea = 1'b0;
    tick();
  endtask

  task automatic decode_log();
    int i;
    int prev;
    logic [7:0] b;
    got_bytes.delete();
    gaps.delete();
    first_start = -1;
    bad_frames = 0;
    i = 0;
    prev = -1;
    while (i < tx_log.size()) begin
      if (tx_log[i] == 1'b0) begin
        if (i + 39 >= tx_log.size()) begin
          bad_frames++;
          break;
        end
        for (int s = 0; s < 4; s++) if (tx_log[i+s] !== 1'b0) bad_frames++;
        for (int k = 0; k < 8; k++) b[k] = tx_log[i + 4*(k+1) + 2];
        for (int s = 36; s < 40; s++) if (tx_log[i+s] !== 1'b1) bad_frames++;
        if (prev < 0) first_start = i;
        else          gaps.push_back(i - prev - 40);
        got_bytes.push_back(b);
        prev = i;
        i += 40;
      end else begin
        i++;
      end
    end
  endtask

  function automatic logic [63:0] pack_bytes();
    logic [63:0] p = '0;
    foreach (got_bytes[j]) p = (p << 8) | 64'(got_bytes[j]);
    return p;
  endfunction

  function automatic logic [63:0] pack_gaps();
    logic [63:0] p = '0;
    foreach (gaps[j]) p = (p << 8) | 64'(gaps[j] & 8'hFF);
    return p;
  endfunction

  initial begin
    int n;

    // Single byte: reset values, latency, frame shape and busy duration
    reset_dut();
    check_output("rst_tx", tx, 1);
    check_output("rst_busy", tx_busy, 0);
    check_output("rst_empty", fifo_empty, 1);
    check_output("rst_full", fifo_full, 0);
    check_output("rst_count", fifo_count, 0);
    check_output("rst_ovf", ovf, 0);
    disp_dat = 32'h0000_00A5;
    disp_wea = 1'b1;
    tick();
    check_output("t1_count_after_push", fifo_count, 1);
    check_output("t1_empty_after_push", fifo_empty, 0);
    disp_wea = 1'b0;
    tick();
    check_output("t1_tx_at_pop", tx, 1);
    check_output("t1_busy_at_pop", tx_busy, 1);
    check_output("t1_count_at_pop", fifo_count, 0);
    for (int i = 0; i < 60; i++) tick();
    decode_log();
    check_output("t1_frames", got_bytes.size(), 1);
    check_output("t1_byte", pack_bytes(), 64'hA5);
    check_output("t1_start_index", first_start, 3);
    check_output("t1_bad_frames", bad_frames, 0);
    check_output("t1_busy_cycles", busy_total, 40);

    // Level hold: one push only
    reset_dut();
    apply_stimulus(8'h31, 50);
    for (int i = 0; i < 60; i++) tick();
    decode_log();
    check_output("t2_frames", got_bytes.size(), 1);
    check_output("t2_byte", pack_bytes(), 64'h31);
    check_output("t2_count_peak", count_peak, 1);

    // Burst of three
    reset_dut();
    apply_stimulus(8'h01, 2);
    apply_stimulus(8'h02, 2);
    apply_stimulus(8'h03, 2);
    for (int i = 0; i < 150; i++) tick();
    decode_log();
    check_output("t3_frames", got_bytes.size(), 3);
    check_output("t3_bytes", pack_bytes(), 64'h010203);
    check_output("t3_gaps", pack_gaps(), 64'h0101);
    check_output("t3_bad_frames", bad_frames, 0);
    check_output("t3_empty_end", fifo_empty, 1);

    // Overflow, ovf clear, and set-beats-clear
    reset_dut();
    for (int i = 0; i < 6; i++) apply_stimulus(8'hA1 + 8'(i), 1);
    check_output("t4_ovf_set", ovf, 1);
    check_output("t4_full", fifo_full, 1);
    check_output("t4_count", fifo_count, 4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_output("t4_ovf_cleared", ovf, 0);
    disp_dat = 32'h0000_00EE;
    disp_wea = 1'b1;
    ovf_clr = 1'b1;
    tick();
    disp_wea = 1'b0;
    ovf_clr = 1'b0;
    tick();
    check_output("t4_ovf_set_wins", ovf, 1);
    for (int i = 0; i < 240; i++) tick();
    decode_log();
    check_output("t4_frames", got_bytes.size(), 5);
    check_output("t4_bytes", pack_bytes(), 64'hA1A2A3A4A5);
    check_output("t4_gaps", pack_gaps(), 64'h01010101);
    check_output("t4_bad_frames", bad_frames, 0);

    // Full FIFO plus simultaneous pop
    reset_dut();
    for (int i = 0; i < 5; i++) apply_stimulus(8'h40 + 8'(i), 1);
    check_output("t5_full_before", fifo_full, 1);
    n = 0;
    while (tx_busy && n < 200) begin
      tick();
      n++;
    end
    check_output("t5_idle_reached", tx_busy, 0);
    disp_dat = 32'h0000_0077;
    disp_wea = 1'b1;
    tick();
    disp_wea = 1'b0;
    check_output("t5_count", fifo_count, 4);
    check_output("t5_ovf", ovf, 0);
    check_output("t5_busy", tx_busy, 1);

    // Reset during data bit 3 with two bytes queued
    reset_dut();
    apply_stimulus(8'h00, 1);
    apply_stimulus(8'h5A, 1);
    apply_stimulus(8'h5A, 1);
    for (int i = 0; i < 14; i++) tick();
    check_output("t6_tx_low_before", tx, 0);
    check_output("t6_count_before", fifo_count, 2);
    #1 Rst = 1'b1;
    #1;
    check_output("t6_rst_tx", tx, 1);
    check_output("t6_rst_busy", tx_busy, 0);
    check_output("t6_rst_empty", fifo_empty, 1);
    check_output("t6_rst_full", fifo_full, 0);
    check_output("t6_rst_count", fifo_count, 0);
    check_output("t6_rst_ovf", ovf, 0);
    tick();
    tick();
    Rst = 1'b0;
    tx_log.delete();
    for (int i = 0; i < 100; i++) tick();
    decode_log();
    check_output("t6_no_frames", got_bytes.size(), 0);
    check_output("t6_bad_frames", bad_frames, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
